// File: rtl/mem_pkg.sv
// Shared FSM state encoding and default geometry for the memory tester.
package mem_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/mem_wdog.sv
// Per-access wait counter; expired flags the cycle the count reaches TIMEOUT.
// Single-cycle counter, no backpressure: the owner clears it on every new request.
module mem_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the wait cycle whose increment takes the count to TIMEOUT.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_tester.sv
// Write-then-read-back pattern tester; each access costs 2 cycles, done lands 4*length+1 after start.
// Stalls on m_ready per access and aborts the run with timeout after TIMEOUT idle wait cycles.
module mem_tester
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [WIDTH-1:0]      seed,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   offset;
  logic [WIDTH-1:0]      seed_q;

  logic [ADDR_WIDTH:0]   offset_inc;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [WIDTH-1:0]      nxt_data;
  logic                  last;
  logic                  in_wait;
  logic                  miscmp;
  logic                  wd_clr;
  logic                  wd_en;
  logic                  wd_exp;

  always_comb begin
    offset_inc = offset + 1'b1;
    nxt_addr   = base_q + ADDR_WIDTH'(offset_inc);
    nxt_data   = seed_q + WIDTH'(offset_inc);
    last       = (offset == len_q - 1'b1);
    in_wait    = (state == WR_WAIT) || (state == RD_WAIT);
    // m_wdata still holds the expected pattern while the read is outstanding.
    miscmp     = (state == RD_WAIT) && m_ready && (m_rdata != m_wdata);
    wd_clr     = (state == WR_REQ) || (state == RD_REQ);
    wd_en      = in_wait && !m_ready;
  end

  mem_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      base_q         <= '0;
      len_q          <= '0;
      seed_q         <= '0;
      offset         <= '0;
      m_valid        <= 1'b0;
      m_wr_rd        <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= length;
            seed_q         <= seed;
            offset         <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state   <= WR_REQ;
              m_valid <= 1'b1;
              m_wr_rd <= 1'b1;
              m_addr  <= base_addr;
              m_wdata <= seed;
            end
          end
        end
        WR_REQ: begin
          m_valid <= 1'b0;
          state   <= WR_WAIT;
        end
        RD_REQ: begin
          m_valid <= 1'b0;
          state   <= RD_WAIT;
        end
        WR_WAIT, RD_WAIT: begin
          if (m_ready) begin
            if (miscmp) begin
              err_count <= err_count + 1'b1;
              if (err_count == '0) first_err_addr <= m_addr;
            end
            if (last) begin
              offset <= '0;
              if (state == WR_WAIT) begin
                state   <= RD_REQ;
                m_valid <= 1'b1;
                m_wr_rd <= 1'b0;
                m_addr  <= base_q;
                m_wdata <= seed_q;
              end else begin
                state <= DONE;
                done  <= 1'b1;
                pass  <= (err_count == '0) && !miscmp;
              end
            end else begin
              offset  <= offset_inc;
              state   <= (state == WR_WAIT) ? WR_REQ : RD_REQ;
              m_valid <= 1'b1;
              m_addr  <= nxt_addr;
              m_wdata <= nxt_data;
            end
          end else if (wd_exp) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tester.sv
// Directed bench for mem_tester against a one-cycle registered memory model.
module tb_mem_tester;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] length;
  logic [7:0] seed;
  logic       m_valid, m_wr_rd;
  logic [4:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata = '0;
  logic       m_ready = 1'b0;
  logic       busy, done, pass, timeout;
  logic [5:0] err_count;
  logic [4:0] first_err_addr;

  mem_tester dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .seed(seed), .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Memory model: ack and read data one cycle after m_valid; optional bit0 stuck-at-1 at address 5.
  logic [7:0] mem [32];
  bit         ready_en = 1'b1;
  bit         stuck = 1'b0;
  always @(posedge clk) begin
    m_ready <= m_valid && ready_en;
    if (m_valid && m_wr_rd) mem[m_addr] <= m_wdata;
    m_rdata <= (stuck && m_addr == 5'd5) ? (mem[m_addr] | 8'h01) : mem[m_addr];
  end

  logic       acc_wr[$];
  logic [4:0] acc_addr[$];
  logic [7:0] acc_data[$];
  int         ndone = 0;
  always @(negedge clk) begin
    if (m_valid) begin
      acc_wr.push_back(m_wr_rd);
      acc_addr.push_back(m_addr);
      acc_data.push_back(m_wdata);
    end
    if (done) ndone++;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Start a run at the next negedge; returns the cycle (relative to the start edge) that done was seen.
  // inj: cycle at which a second, length-0 start is pulsed while busy (0 = none).
  task automatic do_run(input logic [4:0] b, input logic [5:0] l, input logic [7:0] s,
                        input int inj, output int cyc);
    cyc = -1;
    @(negedge clk);
    base_addr = b; length = l; seed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == inj);
      if (k == inj) length = '0;
      if (done) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) begin
      bad++; total++;
      $display("FAIL done_wait: got none want done within 400 cycles");
    end
  endtask

  typedef struct {
    logic [4:0] base;
    logic [5:0] len;
    logic [7:0] seed;
    bit         stuck;
    int         inj;
    int         cyc;
    bit         pass;
    int         err;
    int         first;
    int         nacc;
  } vec_t;

  vec_t vecs[9];

  task automatic apply_vec(input vec_t v, input string tag);
    int cyc, idx0, nd0;
    idx0 = acc_addr.size();
    nd0  = ndone;
    stuck = v.stuck;
    do_run(v.base, v.len, v.seed, v.inj, cyc);
    chk({tag, " done_cycle"}, cyc, v.cyc);
    chk({tag, " pass"}, pass, v.pass);
    chk({tag, " err_count"}, err_count, v.err);
    chk({tag, " first_err"}, first_err_addr, v.first);
    chk({tag, " timeout"}, timeout, 0);
    chk({tag, " busy_in_done"}, busy, 1);
    chk({tag, " n_access"}, acc_addr.size() - idx0, v.nacc);
    for (int i = 0; i < v.nacc && idx0 + i < acc_addr.size(); i++) begin
      int off;
      off = i % v.len;
      chk($sformatf("%s acc%0d wr", tag, i), acc_wr[idx0+i], (i < v.len) ? 1 : 0);
      chk($sformatf("%s acc%0d addr", tag, i), acc_addr[idx0+i], (v.base + off) % 32);
      chk($sformatf("%s acc%0d data", tag, i), acc_data[idx0+i], (v.seed + off) % 256);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " one_done"}, ndone - nd0, 1);
  endtask

  initial begin
    int cyc, nd0, idx0;
    // Pattern 0x05 at address 5 already has bit0 set, so the stuck bit is masked with seed 0; seed 1 exposes it.
    vecs[0] = '{5'd0,  6'd32, 8'hA5, 1'b0, 0,  129, 1'b1, 0, 0, 64};
    vecs[1] = '{5'd30, 6'd4,  8'h10, 1'b0, 0,  17,  1'b1, 0, 0, 8};
    vecs[2] = '{5'd0,  6'd8,  8'h01, 1'b1, 0,  33,  1'b0, 1, 5, 16};
    vecs[3] = '{5'd0,  6'd8,  8'h00, 1'b1, 0,  33,  1'b1, 0, 0, 16};
    vecs[4] = '{5'd0,  6'd0,  8'h33, 1'b0, 0,  1,   1'b1, 0, 0, 0};
    vecs[5] = '{5'd31, 6'd32, 8'hFE, 1'b1, 0,  129, 1'b0, 1, 5, 64};
    vecs[6] = '{5'd3,  6'd1,  8'hFF, 1'b0, 0,  5,   1'b1, 0, 0, 2};
    vecs[7] = '{5'd0,  6'd2,  8'h40, 1'b0, 3,  9,   1'b1, 0, 0, 4};
    vecs[8] = '{5'd10, 6'd3,  8'h80, 1'b0, 13, 13,  1'b1, 0, 0, 6};

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst m_wr_rd", m_wr_rd, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst err_count", err_count, 0);
    chk("rst first_err", first_err_addr, 0);
    chk("rst timeout", timeout, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("v%0d", i));
    stuck = 1'b0;

    // Memory never acknowledges: one request, 15 wait cycles, then done with timeout.
    ready_en = 1'b0;
    idx0 = acc_addr.size();
    do_run(5'd0, 6'd4, 8'h00, 0, cyc);
    chk("to done_cycle", cyc, 17);
    chk("to timeout", timeout, 1);
    chk("to pass", pass, 0);
    chk("to n_access", acc_addr.size() - idx0, 1);
    ready_en = 1'b1;
    @(negedge clk);
    chk("to busy_after", busy, 0);
    apply_vec(vecs[1], "after_to");

    // Reset while a read is outstanding.
    nd0 = ndone;
    @(negedge clk);
    base_addr = 5'd0; length = 6'd4; seed = 8'h20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_valid && !m_wr_rd) begin
        cyc = k;
        break;
      end
    end
    chk("mid read_seen", cyc >= 0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid busy", busy, 0);
    chk("mid m_valid", m_valid, 0);
    chk("mid done", done, 0);
    chk("mid err_count", err_count, 0);
    chk("mid no_done", ndone - nd0, 0);
    apply_vec(vecs[6], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
